// File: rtl/srmt_restore_ctrl.sv
// srmt_restore_ctrl
//   Speculative rename map restore controller. After a pipeline flush it
//   copies the committed rename map (CRMT) into the speculative map (SRMT)
//   two logical registers per cycle. This takes 16 cycles for all 32
//   registers. While a restore is running, rename writes are discarded and
//   rename is stalled. Outside a restore, rename writes pass straight through
//   to the SRMT.
//
//   Optional feature macro: SRMT_RESTORE_REDO_EN
//     If this macro is defined, a retire (crmt_upd_i) during a restore
//     forces another full pass. The done pulse is issued only after a pass
//     with no retire in it.
//
// Ports
//   cpu_clk_i, cpu_rst_i          clock, async active-high reset
//   flush_i                       start/restart a restore
//   rn_w{0,1}_{logical,phys,we}_i rename-stage write requests
//   crmt_addr{0,1}_o              committed-map read addresses
//   crmt_data{0,1}_i              committed-map read data (combinational)
//   crmt_upd_i                    committed map written this cycle
//   srmt_w{0,1}_{logical,phys,we}_o speculative-map write ports
//   rename_stall_o                rename must hold
//   restore_done_o                one-cycle pulse when the restore completes
//
// State table
//   IDLE    | rename writes pass through to the SRMT
//   RESTORE | copy CRMT pair idx into the SRMT each cycle
module srmt_restore_ctrl (
  input  logic       cpu_clk_i,
  input  logic       cpu_rst_i,
  input  logic       flush_i,
  input  logic [4:0] rn_w0_logical_i,
  input  logic [5:0] rn_w0_phys_i,
  input  logic       rn_w0_we_i,
  input  logic [4:0] rn_w1_logical_i,
  input  logic [5:0] rn_w1_phys_i,
  input  logic       rn_w1_we_i,
  output logic [4:0] crmt_addr0_o,
  output logic [4:0] crmt_addr1_o,
  input  logic [5:0] crmt_data0_i,
  input  logic [5:0] crmt_data1_i,
  input  logic       crmt_upd_i,
  output logic [4:0] srmt_w0_logical_o,
  output logic [5:0] srmt_w0_phys_o,
  output logic       srmt_w0_we_o,
  output logic [4:0] srmt_w1_logical_o,
  output logic [5:0] srmt_w1_phys_o,
  output logic       srmt_w1_we_o,
  output logic       rename_stall_o,
  output logic       restore_done_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       done_q, done_d;
  logic       redo_q, redo_d;
  logic       redo_hit;

`ifdef SRMT_RESTORE_REDO_EN
  // A retire in the final cycle of a pass also counts, because the
  // retire's CRMT write would otherwise be lost for pairs already copied.
  assign redo_hit = redo_q | crmt_upd_i;

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) redo_q <= 1'b0;
    else           redo_q <= redo_d;
  end
`else
  logic unused_crmt_upd;
  logic unused_redo_d;
  assign unused_crmt_upd = crmt_upd_i;
  assign unused_redo_d   = redo_d;
  assign redo_hit        = 1'b0;
  assign redo_q          = 1'b0;
`endif

  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
    if (cpu_rst_i) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    redo_d  = redo_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = RESTORE;
          idx_d   = 4'd0;
          redo_d  = 1'b0;
        end
      end
      RESTORE: begin
        if (flush_i) begin
          idx_d  = 4'd0;
          redo_d = 1'b0;
        end else if (idx_q == 4'hf) begin
          idx_d  = 4'd0;
          redo_d = 1'b0;
          if (!redo_hit) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          idx_d  = idx_q + 4'd1;
          redo_d = redo_hit;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    crmt_addr0_o      = 5'd0;
    crmt_addr1_o      = 5'd0;
    srmt_w0_logical_o = rn_w0_logical_i;
    srmt_w0_phys_o    = rn_w0_phys_i;
    // In reset, the flush input only drives the stall output. The rename
    // writes are passed through unchanged.
    srmt_w0_we_o      = rn_w0_we_i & ~(flush_i & ~cpu_rst_i);
    srmt_w1_logical_o = rn_w1_logical_i;
    srmt_w1_phys_o    = rn_w1_phys_i;
    srmt_w1_we_o      = rn_w1_we_i & ~(flush_i & ~cpu_rst_i);
    rename_stall_o    = flush_i;
    if (state_q == RESTORE) begin
      crmt_addr0_o      = {idx_q, 1'b0};
      crmt_addr1_o      = {idx_q, 1'b1};
      srmt_w0_logical_o = {idx_q, 1'b0};
      srmt_w0_phys_o    = crmt_data0_i;
      srmt_w0_we_o      = 1'b1;
      srmt_w1_logical_o = {idx_q, 1'b1};
      srmt_w1_phys_o    = crmt_data1_i;
      srmt_w1_we_o      = 1'b1;
      rename_stall_o    = 1'b1;
    end
  end

  assign restore_done_o = done_q;

endmodule

// File: tb/tb_srmt_restore_ctrl.sv
module tb_srmt_restore_ctrl;

  logic       clk = 1'b0;
  logic       cpu_rst_i;
  logic       flush_i;
  logic [4:0] rn_w0_logical_i, rn_w1_logical_i;
  logic [5:0] rn_w0_phys_i, rn_w1_phys_i;
  logic       rn_w0_we_i, rn_w1_we_i;
  logic [4:0] crmt_addr0_o, crmt_addr1_o;
  logic [5:0] crmt_data0_i, crmt_data1_i;
  logic       crmt_upd_i;
  logic [4:0] srmt_w0_logical_o, srmt_w1_logical_o;
  logic [5:0] srmt_w0_phys_o, srmt_w1_phys_o;
  logic       srmt_w0_we_o, srmt_w1_we_o;
  logic       rename_stall_o, restore_done_o;

  logic [5:0] cmap [32];
  assign crmt_data0_i = cmap[crmt_addr0_o];
  assign crmt_data1_i = cmap[crmt_addr1_o];

  always #5 clk = ~clk;

  srmt_restore_ctrl dut (
    .cpu_clk_i(clk), .cpu_rst_i(cpu_rst_i), .flush_i(flush_i),
    .rn_w0_logical_i(rn_w0_logical_i), .rn_w0_phys_i(rn_w0_phys_i), .rn_w0_we_i(rn_w0_we_i),
    .rn_w1_logical_i(rn_w1_logical_i), .rn_w1_phys_i(rn_w1_phys_i), .rn_w1_we_i(rn_w1_we_i),
    .crmt_addr0_o(crmt_addr0_o), .crmt_addr1_o(crmt_addr1_o),
    .crmt_data0_i(crmt_data0_i), .crmt_data1_i(crmt_data1_i), .crmt_upd_i(crmt_upd_i),
    .srmt_w0_logical_o(srmt_w0_logical_o), .srmt_w0_phys_o(srmt_w0_phys_o), .srmt_w0_we_o(srmt_w0_we_o),
    .srmt_w1_logical_o(srmt_w1_logical_o), .srmt_w1_phys_o(srmt_w1_phys_o), .srmt_w1_we_o(srmt_w1_we_o),
    .rename_stall_o(rename_stall_o), .restore_done_o(restore_done_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: restoring = a copy is in progress; pair = which pair of
  // logical registers is being copied this cycle; dirty = the committed map
  // changed during the current pass; done_now = a pass finished last cycle.
  bit restoring = 1'b0;
  int pair      = 0;
  bit dirty     = 1'b0;
  bit done_now  = 1'b0;
  bit last_done;
  bit mutate_cmap = 1'b0;

`ifdef SRMT_RESTORE_REDO_EN
  localparam bit REDO = 1'b1;
`else
  localparam bit REDO = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    restoring = 1'b0; pair = 0; dirty = 1'b0; done_now = 1'b0;
  endtask

  task automatic check_outputs();
    bit fg;
    fg = flush_i & ~cpu_rst_i;
    last_done = restore_done_o;
    check("stall", {31'd0, rename_stall_o}, {31'd0, restoring | flush_i});
    check("done", {31'd0, restore_done_o}, {31'd0, done_now});
    if (restoring) begin
      check("addr0", {27'd0, crmt_addr0_o}, 2 * pair);
      check("addr1", {27'd0, crmt_addr1_o}, 2 * pair + 1);
      check("w0_log", {27'd0, srmt_w0_logical_o}, 2 * pair);
      check("w1_log", {27'd0, srmt_w1_logical_o}, 2 * pair + 1);
      check("w0_phys", {26'd0, srmt_w0_phys_o}, {26'd0, cmap[2 * pair]});
      check("w1_phys", {26'd0, srmt_w1_phys_o}, {26'd0, cmap[2 * pair + 1]});
      check("w0_we", {31'd0, srmt_w0_we_o}, 32'd1);
      check("w1_we", {31'd0, srmt_w1_we_o}, 32'd1);
    end else begin
      check("addr0_idle", {27'd0, crmt_addr0_o}, 32'd0);
      check("addr1_idle", {27'd0, crmt_addr1_o}, 32'd0);
      check("w0_log_pt", {27'd0, srmt_w0_logical_o}, {27'd0, rn_w0_logical_i});
      check("w1_log_pt", {27'd0, srmt_w1_logical_o}, {27'd0, rn_w1_logical_i});
      check("w0_phys_pt", {26'd0, srmt_w0_phys_o}, {26'd0, rn_w0_phys_i});
      check("w1_phys_pt", {26'd0, srmt_w1_phys_o}, {26'd0, rn_w1_phys_i});
      check("w0_we_pt", {31'd0, srmt_w0_we_o}, {31'd0, rn_w0_we_i & ~fg});
      check("w1_we_pt", {31'd0, srmt_w1_we_o}, {31'd0, rn_w1_we_i & ~fg});
    end
  endtask

  // One clock edge according to the rules: a flush (re)starts the copy at
  // pair 0. Each cycle advances one pair. When pair 15 is finished, the copy
  // ends (with a done pulse) or starts again if the committed map was dirty.
  task automatic model_step(input bit fl, input bit up);
    bit finish;
    finish = 1'b0;
    if (fl) begin
      restoring = 1'b1; pair = 0; dirty = 1'b0;
    end else if (restoring) begin
      dirty = dirty | (REDO & up);
      pair  = pair + 1;
      if (pair == 16) begin
        pair = 0;
        if (dirty) dirty = 1'b0;
        else begin restoring = 1'b0; finish = 1'b1; end
      end
    end
    done_now = finish;
  endtask

  task automatic cycle(input bit fl, input bit up,
                       input logic [4:0] l0, input logic [5:0] p0, input logic we0,
                       input logic [4:0] l1, input logic [5:0] p1, input logic we1);
    @(negedge clk);
    flush_i = fl; crmt_upd_i = up;
    rn_w0_logical_i = l0; rn_w0_phys_i = p0; rn_w0_we_i = we0;
    rn_w1_logical_i = l1; rn_w1_phys_i = p1; rn_w1_we_i = we1;
    if (mutate_cmap) cmap[5'($urandom)] = 6'($urandom);
    #1 check_outputs();
    @(posedge clk);
    model_step(fl, up);
  endtask

  task automatic rcycle(input bit fl, input bit up);
    cycle(fl, up, 5'($urandom), 6'($urandom), 1'($urandom),
          5'($urandom), 6'($urandom), 1'($urandom));
  endtask

  // Run idle cycles until a done pulse is seen (bounded). Then compare the
  // elapsed cycle count, measured from the reference cycle, with the
  // expected count.
  task automatic wait_done(input int start_n, input int exp, input string tag);
    int n;
    n = start_n;
    while (n < 80) begin
      rcycle(1'b0, 1'b0);
      n++;
      if (last_done) break;
    end
    check(tag, n, exp);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) cmap[r] = 6'(32 + r);
    cpu_rst_i = 1'b1; flush_i = 1'b0; crmt_upd_i = 1'b0;
    rn_w0_logical_i = 5'd9; rn_w0_phys_i = 6'd17; rn_w0_we_i = 1'b1;
    rn_w1_logical_i = 5'd4; rn_w1_phys_i = 6'd60; rn_w1_we_i = 1'b1;
    model_reset();
    #3 check_outputs();
    flush_i = 1'b1;
    #1 check_outputs();
    check("rst_we0_with_flush", {31'd0, srmt_w0_we_o}, 32'd1);
    flush_i = 1'b0;
    @(posedge clk); @(negedge clk);
    cpu_rst_i = 1'b0;

    // IDLE pass-through.
    cycle(1'b0, 1'b0, 5'd3, 6'd45, 1'b1, 5'd7, 6'd12, 1'b1);
    // A flush in IDLE blocks rename writes in the same cycle.
    cycle(1'b1, 1'b0, 5'd3, 6'd45, 1'b1, 5'd7, 6'd12, 1'b1);
    check("flush_blocks_we0", {31'd0, srmt_w0_we_o}, 32'd0);
    // Basic restore: done 17 cycles after the flush.
    wait_done(0, 17, "done_latency");
    for (int i = 0; i < 4; i++) rcycle(1'b0, 1'b0);

    // Restart: second flush 8 cycles after the first.
    rcycle(1'b1, 1'b0);
    for (int i = 1; i < 8; i++) rcycle(1'b0, 1'b0);
    rcycle(1'b1, 1'b0);
    wait_done(0, 17, "restart_latency");
    rcycle(1'b0, 1'b0);

    // Retire during the pass (cycle 10 after the flush).
    rcycle(1'b1, 1'b0);
    for (int i = 1; i < 10; i++) rcycle(1'b0, 1'b0);
    rcycle(1'b0, 1'b1);
    wait_done(10, REDO ? 33 : 17, "redo_latency");
    rcycle(1'b0, 1'b0);

    // Asynchronous reset when idx = 6.
    rcycle(1'b1, 1'b0);
    for (int i = 1; i < 7; i++) rcycle(1'b0, 1'b0);
    @(negedge clk);
    flush_i = 1'b0;
    #2 cpu_rst_i = 1'b1;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    @(negedge clk);
    cpu_rst_i = 1'b0;
    for (int i = 0; i < 20; i++) rcycle(1'b0, 1'b0);

    // Random traffic with a changing committed map.
    mutate_cmap = 1'b1;
    for (int i = 0; i < 600; i++)
      rcycle($urandom_range(39, 0) == 0, $urandom_range(3, 0) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/srmt_restore_ctrl.md
SRMT_RESTORE_CTRL -- requirements
Module: srmt_restore_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 cpu_clk_i  in  1  core clock; all state on rising edge.
REQ-003 cpu_rst_i  in  1  asynchronous active-high reset.
REQ-004 flush_i  in  1  pipeline flush; starts (or restarts) a restore of the speculative map from the committed map.
REQ-005 rn_w0_logical_i / rn_w0_phys_i / rn_w0_we_i  in  5/6/1  rename-stage write port 0 request.
REQ-006 rn_w1_logical_i / rn_w1_phys_i / rn_w1_we_i  in  5/6/1  rename-stage write port 1 request.
REQ-007 crmt_addr0_o / crmt_addr1_o  out  5/5  committed-map read addresses.
REQ-008 crmt_data0_i / crmt_data1_i  in  6/6  committed-map read data, combinational, same cycle as address.
REQ-009 crmt_upd_i  in  1  committed map written this cycle (retire).
REQ-010 srmt_w0_logical_o / srmt_w0_phys_o / srmt_w0_we_o  out  5/6/1  speculative-map write port 0.
REQ-011 srmt_w1_logical_o / srmt_w1_phys_o / srmt_w1_we_o  out  5/6/1  speculative-map write port 1.
REQ-012 rename_stall_o  out  1  rename must hold; its writes are being discarded.
REQ-013 restore_done_o  out  1  registered single-cycle pulse: restore complete.

Function
REQ-014 FSM states SHALL be IDLE and RESTORE; a 4-bit pair index idx SHALL select logical registers 2*idx (port 0) and 2*idx+1 (port 1).
REQ-015 IDLE: srmt_w* outputs SHALL equal rn_w* inputs combinationally (pure pass-through); crmt_addr*_o SHALL be 0.
REQ-016 IDLE with flush_i=1: srmt_w0_we_o and srmt_w1_we_o SHALL be 0 that cycle; next state RESTORE, idx<=0.
REQ-017 RESTORE: crmt_addr0_o=2*idx, crmt_addr1_o=2*idx+1; srmt_w0 = {2*idx, crmt_data0_i, we=1}; srmt_w1 = {2*idx+1, crmt_data1_i, we=1}; rn_w* ignored.
REQ-018 RESTORE: idx SHALL increment by 1 per cycle; a full pass is 16 cycles covering all 32 logical registers including x0.
REQ-019 Flush at cycle N: first restore write cycle N+1, last write N+16, RESTORE->IDLE at N+17, restore_done_o=1 at N+17 only.
REQ-020 flush_i=1 during RESTORE SHALL restart: idx<=0, redo flag cleared, no done pulse; writes that cycle still occur per REQ-017.
REQ-021 rename_stall_o SHALL be 1 whenever state=RESTORE or flush_i=1, else 0.
REQ-022 Port 0 and port 1 logical addresses in RESTORE are always distinct, so no same-address write drop can occur.
REQ-023 idx=15 with no restart and no pending redo SHALL transition to IDLE; idx wraps to 0.

Reset
REQ-024 cpu_rst_i=1 SHALL force state=IDLE, idx=0, redo=0, restore_done_o=0 immediately, independent of clock.
REQ-025 Reset mid-RESTORE SHALL abort the pass with no done pulse; out of reset, outputs follow REQ-015.
REQ-026 Reset-state outputs: srmt_w*_we_o = rn_w*_we_i, rename_stall_o = flush_i, crmt_addr*_o = 0.

Configuration
REQ-027 Macro SRMT_RESTORE_REDO_EN SHALL select retire-during-restore handling.
REQ-028 With SRMT_RESTORE_REDO_EN: crmt_upd_i=1 in any RESTORE cycle sets redo; at idx=15 with redo set (or crmt_upd_i=1 that cycle), idx<=0, redo<=0, stay RESTORE, no done pulse; done follows the first clean pass.
REQ-029 Without SRMT_RESTORE_REDO_EN: crmt_upd_i SHALL be ignored; redo flag absent; exactly one 16-cycle pass per flush.

Verification
REQ-030 Reset, flush_i pulse at cycle 5, crmt returns 32+r for reg r -> writes pairs (0,1)...(30,31) cycles 6-21, data 32..63, done at 22, stall cycles 5-21.
REQ-031 IDLE, rn_w0={3,45,1}, rn_w1={7,12,1} -> srmt_w0={3,45,1}, srmt_w1={7,12,1} same cycle, stall=0.
REQ-032 flush at 0, second flush at 8 -> idx restarts at 0 in cycle 9, last write cycle 24, done only at 25.
REQ-033 REDO_EN, crmt_upd_i at cycle 10 of a pass -> second full pass, done 16 cycles later than REQ-030; without macro, done at original cycle.
REQ-034 cpu_rst_i asserted asynchronously mid-pass (idx=6) -> state IDLE, stall follows flush_i, no done pulse; rename pass-through resumes.
REQ-035 flush_i with rn_w0_we_i=1 in IDLE -> srmt_w0_we_o=0 that cycle.
